// File: rtl/alu_operand_arbiter.sv
// Round-robin arbiter sharing one registered operand bus between requesters A and B.
// Optional saturating accept counters are enabled by defining ALU_ARB_PERF_EN.
module alu_operand_arbiter #(
    parameter int W     = 31,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [W:0]       a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [W:0]       b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W:0]       out_data,
    output logic             out_src
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    logic       prio;
    logic       load_p0;
    logic       pick_a_p0;
    logic       pick_b_p0;
    logic [W:0] sel_data_p0;

    // Stage p0: load enable, winner pick and 2:1 operand select
    assign load_p0     = rst_n && (!out_valid || out_ready);
    assign pick_a_p0   = a_valid && (!b_valid || prio);
    assign pick_b_p0   = b_valid && !pick_a_p0;
    assign a_ready     = load_p0 && pick_a_p0;
    assign b_ready     = load_p0 && pick_b_p0;
    assign sel_data_p0 = pick_a_p0 ? a_data : b_data;

    // Stage p1: output register, source tag and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            prio      <= 1'b1;
        end else if (load_p0) begin
            if (a_ready || b_ready) begin
                out_valid <= 1'b1;
                out_data  <= sel_data_p0;
                out_src   <= a_ready;
                prio      <= b_ready;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_ready) a_count <= sat_inc(a_count);
            if (b_ready) b_count <= sat_inc(b_count);
        end
    end
`endif

endmodule
